imem_boot_loader: RTL and testbench

- Boot sequencer for the single-cycle CPU.
- Streams a program image into instruction memory through the CPU's initialize port, then holds the CPU reset for a fixed time.
- Releases the CPU to run and optionally stops it after a programmed cycle budget.
- Sits between the testbench/host word stream and the cpu top-level inputs (rst, initialize, instruction_initialize_data, instruction_initialize_address).

---
 rtl/imem_boot_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot sequencer: streams an image into instruction memory, holds and releases CPU reset
//
// Loads a program image into instruction memory through the CPU initialize port,
// then holds the CPU in reset for RESET_HOLD cycles and lets it run, optionally
// for a fixed cycle budget.
//
// Optional feature: define IMEM_BOOT_CHECKSUM_EN to treat the s_last word as a
// 32-bit modular checksum of the written words instead of an instruction.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, abort    begin a load (from IDLE/DONE/ERROR) / return to IDLE
//   s_valid, s_ready, s_data, s_last   image word stream
//   run_limit       CPU cycle budget, 0 = unlimited, sampled on entry to RUN
//   init_en, init_addr, init_data      CPU instruction-memory initialize port
//   cpu_rst         CPU reset
//   busy, done, error, words_loaded    status
module imem_boot_loader #(
  parameter int unsigned DEPTH      = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [31:0] run_limit,
  output logic        init_en,
  output logic [31:0] init_addr,
  output logic [31:0] init_data,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [15:0] DEPTH_W   = 16'(DEPTH);
  localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr;
  logic [31:0] hold_cnt;
  logic [31:0] cyc_cnt;
  logic [31:0] limit;
  logic        hs;
  logic        wr;
  logic        over;
  logic        restart;
  logic [15:0] wl_inc;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] sum;
  logic        last_ok;

  // The checksum word itself is never written.
  assign wr      = hs & ~abort & ~s_last;
  assign last_ok = (sum == s_data);
`else
  logic        last_ok;

  assign wr      = hs & ~abort;
  assign last_ok = 1'b1;
`endif

  assign hs      = s_valid & s_ready;
  assign wl_inc  = (words_loaded == 16'hFFFF) ? words_loaded : words_loaded + 16'd1;
  assign over    = (wl_inc == DEPTH_W);
  assign restart = start & ~abort &
                   ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    cpu_rst   = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;

    case (state)
      S_LOAD:  begin s_ready = 1'b1; busy = 1'b1; end
      S_HOLD:  busy = 1'b1;
      S_RUN:   begin cpu_rst = 1'b0; busy = 1'b1; end
      S_DONE:  done = 1'b1;
      S_ERROR: error = 1'b1;
      default: ;
    endcase

    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) state_nxt = S_LOAD;
        end
        S_LOAD: begin
          if (hs) begin
            if (s_last)    state_nxt = last_ok ? S_HOLD : S_ERROR;
            else if (over) state_nxt = S_ERROR;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
        end
        S_RUN: begin
          if ((limit != 32'd0) && (cyc_cnt == limit - 32'd1)) state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      init_en      <= 1'b0;
      init_addr    <= 32'd0;
      init_data    <= 32'd0;
      words_loaded <= 16'd0;
      addr         <= BASE_ADDR;
      hold_cnt     <= 32'd0;
      cyc_cnt      <= 32'd0;
      limit        <= 32'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum          <= 32'd0;
`endif
    end else begin
      state   <= state_nxt;
      init_en <= wr;

      if (wr) begin
        init_addr    <= addr;
        init_data    <= s_data;
        addr         <= addr + 32'd4;
        words_loaded <= wl_inc;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum          <= sum + s_data;
`endif
      end

      // wr only happens in LOAD, so it never collides with a restart.
      if (restart) begin
        addr         <= BASE_ADDR;
        words_loaded <= 16'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum          <= 32'd0;
`endif
      end

      // Counting starts on the cycle the final write is presented on init_en.
      hold_cnt <= (state == S_HOLD) ? hold_cnt + 32'd1 : 32'd0;

      if ((state == S_HOLD) && (state_nxt == S_RUN)) begin
        limit   <= run_limit;
        cyc_cnt <= 32'd0;
      end else if (state == S_RUN) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam int          DEPTH = 4;
  localparam int          HOLD  = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'd0;
  logic        s_last = 1'b0;
  logic [31:0] run_limit = 32'd0;
  logic        init_en;
  logic [31:0] init_addr;
  logic [31:0] init_data;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_boot_loader #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .RESET_HOLD(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .run_limit(run_limit),
    .init_en(init_en),
    .init_addr(init_addr),
    .init_data(init_data),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_wr_cyc = 0;
  int          hs_cyc   = 0;
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic        exp_err;
  int          exp_n;
  logic [31:0] img [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All waiting goes through here; every write on the init port is captured.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (init_en === 1'b1) begin
      wq_a.push_back(init_addr);
      wq_d.push_back(init_data);
      last_wr_cyc = cyc;
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({p, "_init_en"}, 32'(init_en), 32'd0);
    chk({p, "_init_addr"}, init_addr, 32'd0);
    chk({p, "_init_data"}, init_data, 32'd0);
    chk({p, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({p, "_busy"}, 32'(busy), 32'd0);
    chk({p, "_done"}, 32'(done), 32'd0);
    chk({p, "_error"}, 32'(error), 32'd0);
    chk({p, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  // Reference: walk the image word by word applying the load rules.
  task automatic model(input int len, input int last_idx);
    int          cnt;
    logic [31:0] sum;
    cnt = 0;
    sum = 32'd0;
    exp_a.delete();
    exp_d.delete();
    exp_err = 1'b0;
    exp_n = 0;
    for (int i = 0; i < len; i++) begin
      exp_n = i + 1;
      if (i == last_idx) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
        exp_err = (sum != img[i]);
`else
        exp_a.push_back(BASE + 32'(4 * cnt));
        exp_d.push_back(img[i]);
`endif
        return;
      end
      exp_a.push_back(BASE + 32'(4 * cnt));
      exp_d.push_back(img[i]);
      sum += img[i];
      cnt++;
      if (cnt == DEPTH) begin
        exp_err = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: s_valid always high, 1: toggling 1,0,1,..., 2: random
  task automatic feed(input int n, input int last_idx, input int mode);
    int i;
    int c;
    i = 0;
    c = 0;
    while (i < n && c < 300) begin
      s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2 == 0) : 1'($urandom % 2);
      s_data  = img[i];
      s_last  = (i == last_idx);
      if (s_valid && s_ready) begin
        hs_cyc = cyc + 1;
        i++;
      end
      tick();
      c++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("feed_accepted", 32'(i), 32'(n));
  endtask

  task automatic run_one(input string tag, input int len, input int last_idx,
                         input int mode, input logic [31:0] lim);
    int g;
    wq_a.delete();
    wq_d.delete();
    run_limit = lim;
    model(len, last_idx);
    pulse_start();
    chk({tag, "_busy_load"}, 32'(busy), 32'd1);
    feed(exp_n, last_idx, mode);
    tick();
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_a.size()));
    if (exp_err) begin
      chk({tag, "_error"}, 32'(error), 32'd1);
      chk({tag, "_err_s_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_err_cpu_rst"}, 32'(cpu_rst), 32'd1);
      s_valid = 1'b1;
      s_data  = 32'hDEAD_BEEF;
      tick();
      tick();
      s_valid = 1'b0;
      chk({tag, "_err_sticky"}, 32'(error), 32'd1);
    end else begin
      g = 0;
      while (cpu_rst && g < 50) begin
        tick();
        g++;
      end
      chk({tag, "_release_delay"}, 32'(cyc - hs_cyc), 32'(HOLD));
`ifndef IMEM_BOOT_CHECKSUM_EN
      chk({tag, "_release_after_write"}, 32'(cyc - last_wr_cyc), 32'(HOLD));
`endif
      if (lim != 32'd0) begin
        g = 0;
        while (!cpu_rst && g < 200) begin
          tick();
          g++;
        end
        chk({tag, "_run_cycles"}, 32'(g), lim);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
      end else begin
        for (int k = 0; k < 8; k++) tick();
        chk({tag, "_unlim_running"}, 32'(cpu_rst), 32'd0);
        pulse_start();
        chk({tag, "_start_ignored"}, 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk({tag, "_abort_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
      end
    end
    chk({tag, "_n_writes"}, 32'(wq_a.size()), 32'(exp_a.size()));
    for (int k = 0; k < exp_a.size() && k < wq_a.size(); k++) begin
      chk({tag, "_wr_addr"}, wq_a[k], exp_a[k]);
      chk({tag, "_wr_data"}, wq_d[k], exp_d[k]);
    end
  endtask

  initial begin
    int          len;
    int          last_idx;
    logic [31:0] s;

    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();
    chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);

    img[0] = 32'h2001_0005;
    img[1] = 32'h2002_0003;
    img[2] = 32'h0022_1820;
    run_one("basic", 3, 2, 0, 32'd10);
    run_one("toggle", 3, 2, 1, 32'd0);
    run_one("reload", 3, 2, 0, 32'd1);

    for (int k = 0; k < DEPTH; k++) img[k] = 32'h1000_0000 + 32'(k);
    run_one("overflow", 6, -1, 0, 32'd0);

`ifdef IMEM_BOOT_CHECKSUM_EN
    img[0] = 32'h1;
    img[1] = 32'h2;
    img[2] = 32'h3;
    run_one("cks_good", 3, 2, 0, 32'd3);
    img[2] = 32'h4;
    run_one("cks_bad", 3, 2, 0, 32'd3);
`endif

    // abort on the second handshake
    wq_a.delete();
    wq_d.delete();
    img[0] = 32'hA5A5_0001;
    img[1] = 32'hA5A5_0002;
    pulse_start();
    s_valid = 1'b1;
    s_data  = img[0];
    tick();
    s_data  = img[1];
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abort_init_en", 32'(init_en), 32'd0);
    chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort_s_ready", 32'(s_ready), 32'd0);
    tick();
    chk("abort_n_writes", 32'(wq_a.size()), 32'd1);
    if (wq_d.size() > 0) chk("abort_first_data", wq_d[0], img[0]);

    // rst while the CPU is running
    img[0] = 32'h0000_0013;
`ifdef IMEM_BOOT_CHECKSUM_EN
    img[0] = 32'h0;
`endif
    run_limit = 32'd0;
    pulse_start();
    feed(1, 0, 0);
    for (int k = 0; k < HOLD + 3; k++) tick();
    chk("pre_rst_running", 32'(cpu_rst), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_run");

    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(1, 6);
      last_idx = len - 1;
      if ($urandom % 4 == 0) begin
        last_idx = -1;
        len = 6;
      end
      for (int k = 0; k < 8; k++) img[k] = $urandom;
`ifdef IMEM_BOOT_CHECKSUM_EN
      if (last_idx >= 0 && ($urandom % 2 == 0)) begin
        s = 32'd0;
        for (int k = 0; k < last_idx; k++) s += img[k];
        img[last_idx] = s;
      end
`else
      s = 32'd0;
`endif
      run_one("rand", len, last_idx, 2, ($urandom % 3 == 0) ? 32'd0 : 32'($urandom_range(1, 12)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
